fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 29 ++
 rtl/fifo_wr_arbiter_if.sv | 38 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg
//   Shared types and widths for the FIFO write-port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, GRANT)
//   - DEF_*       : default parameter values of the arbiter
//   - GID_W       : grant index width for the default requester count
//   - BCNT_W      : burst counter width for the default MAX_BURST
//   - BEAT_CNT_W  : width of the total-beats counter
//   - idx_width() : index width helper that never returns 0
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_WIDTH     = 512;
  localparam int DEF_MAX_BURST = 16;

  localparam int GID_W      = $clog2(DEF_N_REQ);
  localparam int BCNT_W     = $clog2(DEF_MAX_BURST + 1);
  localparam int BEAT_CNT_W = 32;

  // Index width for n items, at least 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Requester and FIFO write-side signals of the write-port arbiter.
//   slave  : arbiter view (takes requests + fifo_full, drives ready/write/status)
//   master : environment view (requesters, FIFO, monitors)
//   req_valid/req_last/req_ready : per-requester beat handshake
//   req_data  : requester i on bits [i*WIDTH +: WIDTH]
//   fifo_full : FIFO full flag; fifo_wr_en/fifo_data : FIFO write port
//   grant_id/busy/beat_cnt : arbiter status
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int ID_W = idx_width(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_data;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic [BEAT_CNT_W-1:0]  beat_cnt;

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data, grant_id, busy, beat_cnt
  );

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data, grant_id, busy, beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   i_req        : request vector
//   i_last_grant : index of the previous winner
//   o_winner     : first set request searching upward from i_last_grant+1, wrapping
//   o_any_req    : at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic [ID_W-1:0]  o_winner,
  output logic             o_any_req
);

  // w_cand[k] is the requester examined at priority position k.
  logic [ID_W-1:0] w_cand [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign w_cand[gi] = ID_W'((32'(i_last_grant) + 32'(gi) + 32'd1) % 32'(N_REQ));
  end

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_winner = w_cand[k];
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, burst-granular sharing of one FIFO write port between N_REQ
//   requesters. A grant lasts until the grantee's last beat or MAX_BURST beats.
//   Writes are gated by fifo_full so the FIFO never sees a write while full.
//   wr_clk : write-domain clock
//   reset  : synchronous, active-high reset
//   bus    : requester handshake, FIFO write port and status (slave view)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              wr_clk,
  input logic              reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int GRANT_W = idx_width(N_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e              r_state;
  arb_state_e              w_state_next;
  logic [GRANT_W-1:0]      r_grant_id;
  logic [GRANT_W-1:0]      r_last_grant;
  logic [BURST_W-1:0]      r_burst_cnt;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;

  logic [GRANT_W-1:0]      w_winner;
  logic                    w_any_req;
  logic [N_REQ-1:0]        w_ready;
  logic                    w_xfer;
  logic                    w_burst_end;
  logic [WIDTH-1:0]        w_req_data [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (GRANT_W)
  ) u_rr_pick (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
    assign w_req_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // Ready is combinational on fifo_full: the flag lags the filling write by a
  // cycle, so any registered write stage would overrun the FIFO by one beat.
  // Reset also drops ready so a burst cut by reset writes nothing that cycle.
  always_comb begin
    w_ready = '0;
    if (r_state == GRANT && !reset) begin
      w_ready[r_grant_id] = ~bus.fifo_full;
    end
  end

  assign w_xfer      = bus.req_valid[r_grant_id] & w_ready[r_grant_id];
  assign w_burst_end = w_xfer & (bus.req_last[r_grant_id] |
                                 (r_burst_cnt == BURST_W'(MAX_BURST - 1)));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req)   w_state_next = GRANT;
      GRANT:   if (w_burst_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GRANT_W'(N_REQ - 1);
      r_burst_cnt  <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any_req) begin
        r_grant_id <= w_winner;
      end
      if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
        if (w_burst_end) begin
          r_burst_cnt  <= '0;
          r_last_grant <= r_grant_id;
        end else begin
          r_burst_cnt <= r_burst_cnt + BURST_W'(1);
        end
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.fifo_wr_en = w_xfer;
  assign bus.fifo_data  = w_req_data[r_grant_id];
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = (r_state == GRANT);
  assign bus.beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32, MAX_BURST=4).
//   Requester i presents data d + (i << 24), so the written word identifies
//   both the grantee and the beat.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] d;
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [31:0] e_data;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [31:0] e_cnt;
  } vec_t;

  logic wr_clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .wr_clk (wr_clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                       input logic full, input logic [31:0] d);
    bus.req_valid = valid;
    bus.req_last  = last;
    bus.fifo_full = full;
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*W +: W] = d + (32'(i) << 24);
    end
  endtask

  task automatic check(input string name, input logic [3:0] e_ready, input logic e_wr,
                       input logic [31:0] e_data, input logic [1:0] e_gid,
                       input logic e_busy, input logic [31:0] e_cnt);
    bit bad;
    checks++;
    bad = (bus.req_ready !== e_ready) || (bus.fifo_wr_en !== e_wr) ||
          (e_wr && (bus.fifo_data !== e_data)) || (bus.grant_id !== e_gid) ||
          (bus.busy !== e_busy) || (bus.beat_cnt !== e_cnt);
    if (bad) begin
      failures++;
      $display("FAIL %s: got ready=%b wr=%b data=%h gid=%0d busy=%b cnt=%h | want ready=%b wr=%b data=%h gid=%0d busy=%b cnt=%h",
               name, bus.req_ready, bus.fifo_wr_en, bus.fifo_data, bus.grant_id,
               bus.busy, bus.beat_cnt, e_ready, e_wr, e_data, e_gid, e_busy, e_cnt);
    end else begin
      $display("ok   %s: ready=%b wr=%b data=%h gid=%0d busy=%b cnt=%0d",
               name, bus.req_ready, bus.fifo_wr_en, bus.fifo_data, bus.grant_id,
               bus.busy, bus.beat_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    @(negedge wr_clk);
    @(negedge wr_clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [3:0] valid, input logic [3:0] last, input logic full,
                     input logic [31:0] d, input logic [3:0] e_ready, input logic e_wr,
                     input logic [31:0] e_data, input logic [1:0] e_gid,
                     input logic e_busy, input logic [31:0] e_cnt);
    vec_t v;
    v.valid = valid;  v.last = last;  v.full = full;  v.d = d;
    v.e_ready = e_ready;  v.e_wr = e_wr;  v.e_data = e_data;
    v.e_gid = e_gid;  v.e_busy = e_busy;  v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);

    //   valid    last     full d       ready    wr  data          gid busy cnt
    // Single requester 0, 3-beat burst.
    add(4'b0001, 4'b0000, 0, 32'h01, 4'b0000, 0, 32'h0,        0, 0, 0);
    add(4'b0001, 4'b0000, 0, 32'h01, 4'b0001, 1, 32'h00000001, 0, 1, 0);
    add(4'b0001, 4'b0000, 0, 32'h02, 4'b0001, 1, 32'h00000002, 0, 1, 1);
    add(4'b0001, 4'b0001, 0, 32'h03, 4'b0001, 1, 32'h00000003, 0, 1, 2);
    add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 32'h0,        0, 0, 3);
    // Requester 1, fifo_full for two cycles at beat 2.
    add(4'b0010, 4'b0000, 0, 32'h10, 4'b0000, 0, 32'h0,        0, 0, 3);
    add(4'b0010, 4'b0000, 0, 32'h11, 4'b0010, 1, 32'h01000011, 1, 1, 3);
    add(4'b0010, 4'b0000, 1, 32'h12, 4'b0000, 0, 32'h0,        1, 1, 4);
    add(4'b0010, 4'b0000, 1, 32'h12, 4'b0000, 0, 32'h0,        1, 1, 4);
    add(4'b0010, 4'b0000, 0, 32'h12, 4'b0010, 1, 32'h01000012, 1, 1, 4);
    add(4'b0010, 4'b0010, 0, 32'h13, 4'b0010, 1, 32'h01000013, 1, 1, 5);
    add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 32'h0,        1, 0, 6);
    // Requester 1 stalls for 3 cycles while requester 3 waits.
    add(4'b0010, 4'b0000, 0, 32'h20, 4'b0000, 0, 32'h0,        1, 0, 6);
    add(4'b1010, 4'b0000, 0, 32'h20, 4'b0010, 1, 32'h01000020, 1, 1, 6);
    add(4'b1000, 4'b0000, 0, 32'h21, 4'b0010, 0, 32'h0,        1, 1, 7);
    add(4'b1000, 4'b0000, 0, 32'h21, 4'b0010, 0, 32'h0,        1, 1, 7);
    add(4'b1000, 4'b0000, 0, 32'h21, 4'b0010, 0, 32'h0,        1, 1, 7);
    add(4'b1010, 4'b0010, 0, 32'h21, 4'b0010, 1, 32'h01000021, 1, 1, 7);
    add(4'b1000, 4'b0000, 0, 32'h22, 4'b0000, 0, 32'h0,        1, 0, 8);
    add(4'b1000, 4'b1000, 0, 32'h22, 4'b1000, 1, 32'h03000022, 3, 1, 8);
    add(4'b0000, 4'b0000, 0, 32'h00, 4'b0000, 0, 32'h0,        3, 0, 9);

    do_reset();
    #2;
    check("reset_state", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge wr_clk);
      drive(vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].d);
      #2;
      check($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_data,
            vecs[i].e_gid, vecs[i].e_busy, vecs[i].e_cnt);
    end

    // Saturation: all requesters valid, never last -> 0,1,2,3,0 with MB beats each.
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0, 32'h55);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g;
      logic [1:0] prev;
      g    = 2'(k % 4);
      prev = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
      #2;
      check($sformatf("sat_idle%0d", k), 4'b0000, 1'b0, 32'h0, prev, 1'b0, 32'(MB * k));
      for (int b = 0; b < MB; b++) begin
        @(negedge wr_clk);
        #2;
        check($sformatf("sat_g%0d_b%0d", k, b), 4'(1 << g), 1'b1,
              32'h55 + (32'(g) << 24), g, 1'b1, 32'(MB * k + b));
      end
      @(negedge wr_clk);
    end
    #2;
    check("sat_total", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'd20);

    // Reset during beat 2 of requester 2's burst, with requesters 1 and 2 valid.
    do_reset();
    drive(4'b0100, 4'b0000, 1'b0, 32'h30);
    #2;
    check("rst_idle", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
    @(negedge wr_clk);
    drive(4'b0110, 4'b0000, 1'b0, 32'h31);
    #2;
    check("rst_beat1", 4'b0100, 1'b1, 32'h02000031, 2'd2, 1'b1, 32'd0);
    @(negedge wr_clk);
    drive(4'b0110, 4'b0000, 1'b0, 32'h32);
    reset = 1'b1;
    #2;
    check("rst_cycle", 4'b0000, 1'b0, 32'h0, 2'd2, 1'b1, 32'd1);
    @(negedge wr_clk);
    reset = 1'b0;
    #2;
    check("rst_after", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
    @(negedge wr_clk);
    #2;
    check("rst_regrant", 4'b0010, 1'b1, 32'h01000032, 2'd1, 1'b1, 32'd0);

    // beat_cnt wrap at 2^32-1.
    do_reset();
    force dut.r_beat_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_beat_cnt;
    #1;
    check("wrap_preset", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    @(negedge wr_clk);
    drive(4'b0001, 4'b0000, 1'b0, 32'h40);
    #2;
    check("wrap_idle", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'hFFFF_FFFF);
    @(negedge wr_clk);
    drive(4'b0001, 4'b0000, 1'b0, 32'h41);
    #2;
    check("wrap_beat1", 4'b0001, 1'b1, 32'h00000041, 2'd0, 1'b1, 32'hFFFF_FFFF);
    @(negedge wr_clk);
    drive(4'b0001, 4'b0001, 1'b0, 32'h42);
    #2;
    check("wrap_beat2", 4'b0001, 1'b1, 32'h00000042, 2'd0, 1'b1, 32'd0);
    @(negedge wr_clk);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    #2;
    check("wrap_done", 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
